// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128 inverse key expander.
//   Loads round key NUM_ROUNDS on start, then presents round keys
//   NUM_ROUNDS..0 over a valid/ready handshake, one per transfer.
//   The previous key is derived combinationally with 4 forward S-boxes.
// Ports:
//   clk, rst          clock, async active-high reset
//   start, key_in     load key_in (round NUM_ROUNDS) and begin a walk (IDLE only)
//   key_ready         consumer accepts key_out this cycle
//   key_out/round_out registered current round key and its index
//   key_valid         key_out/round_out valid (state RUN)
//   busy              state != IDLE
//   done              one-cycle pulse after round key 0 is accepted

// aes_sbox: forward AES S-box computed as GF(2^8) inverse + affine map.
//   a  input byte,  s  substituted byte
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8) (and maps 0 to 0); square-and-multiply over 11111110b
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r;
  endfunction

  logic [7:0] b;
  assign b = ginv(a);
  assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, nxt_state;
  logic [127:0] cur_key, nxt_key, prev_key;
  logic [3:0]   round, nxt_round, rc_idx;
  logic         nxt_done;
  logic [31:0]  w0n, w1n, w2n, w3n, rot, sub;
  logic [7:0]   rcon;

  // Undo the forward recurrence; w3 must be recovered first since
  // SubWord(RotWord()) in the forward schedule used the old w3.
  assign w3n = cur_key[31:0]  ^ cur_key[63:32];
  assign w2n = cur_key[63:32] ^ cur_key[95:64];
  assign w1n = cur_key[95:64] ^ cur_key[127:96];
  assign rot = {w3n[23:0], w3n[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    aes_sbox u_sb (.a(rot[i*8 +: 8]), .s(sub[i*8 +: 8]));
  end

  // round==0 wraps rc_idx to 15, which maps to 0; that path is never taken anyway
  assign rc_idx = round - 4'd1;
  always_comb begin
    case (rc_idx)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0n      = cur_key[127:96] ^ sub ^ {rcon, 24'h0};
  assign prev_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_key <= '0;
      round   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      cur_key <= nxt_key;
      round   <= nxt_round;
      done    <= nxt_done;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_key   = cur_key;
    nxt_round = round;
    nxt_done  = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt_key   = key_in;
        nxt_round = 4'(NUM_ROUNDS);
        nxt_state = RUN;
      end
      RUN: if (key_ready) begin
        if (round == 4'd0) begin
          nxt_state = IDLE;
          nxt_done  = 1'b1;
        end else begin
          nxt_key   = prev_key;
          nxt_round = round - 4'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign key_out   = cur_key;
  assign round_out = round;
  assign key_valid = (state == RUN);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;
  logic         clk, rst, start, start1, key_ready;
  logic [127:0] key_in, key_out, key_out1;
  logic [3:0]   round_out, round_out1;
  logic         key_valid, busy, done, key_valid1, busy1, done1;
  int total = 0;
  int bad   = 0;

  logic [127:0] fips [0:10];
  logic [127:0] zero10;

  inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .key_out(key_out), .round_out(round_out), .key_valid(key_valid),
    .busy(busy), .done(done));

  inv_key_schedule #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in), .key_ready(key_ready),
    .key_out(key_out1), .round_out(round_out1), .key_valid(key_valid1),
    .busy(busy1), .done(done1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Consumes one walk starting at the first valid negedge; returns at the
  // negedge where done should be high, or early when round stop_r is shown.
  task automatic walk(input bit rnd, input int inj_r, input int stop_r);
    int  r   = 10;
    int  cyc = 0;
    bit  fin = 0;
    while (!fin && cyc < 200) begin
      start     = 1'b0;
      key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("valid", 128'(key_valid), 128'(1));
      chk("busy", 128'(busy), 128'(1));
      chk("done_early", 128'(done), 128'(0));
      chk($sformatf("key_r%0d", r), key_out, fips[r]);
      chk($sformatf("round_r%0d", r), 128'(round_out), 128'(r));
      if (r == inj_r) begin
        start  = 1'b1;
        key_in = zero10;
      end
      if (r == stop_r) return;
      if (key_ready) begin
        if (r == 0) fin = 1;
        else r--;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      total++;
      bad++;
      $error("FAIL walk_timeout observed=%0d expected=done", cyc);
    end else begin
      if (!rnd) chk("cycles", 128'(cyc), 128'(11));
      chk("done_pulse", 128'(done), 128'(1));
      chk("busy_end", 128'(busy), 128'(0));
      chk("valid_end", 128'(key_valid), 128'(0));
    end
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst = 1'b1; start = 1'b0; start1 = 1'b0; key_ready = 1'b1; key_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_key", key_out, 128'(0));
    chk("rst_round", 128'(round_out), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: straight walk, ready held high
    do_start(fips[10]);
    walk(0, -1, -1);
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));

    // 2: random backpressure
    do_start(fips[10]);
    walk(1, -1, -1);
    @(negedge clk);
    chk("done_one_cycle_bp", 128'(done), 128'(0));

    // 3: start with another key while busy is ignored
    do_start(fips[10]);
    walk(1, 6, -1);
    @(negedge clk);
    chk("busy_after_inject", 128'(busy), 128'(0));

    // 4: asynchronous reset mid-walk, then a fresh full walk
    do_start(fips[10]);
    walk(0, -1, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(key_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_key", key_out, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(fips[10]);
    walk(0, -1, -1);

    // 5: start in the done cycle with the all-zero key's round 10 key
    start  = 1'b1;
    key_in = zero10;
    @(negedge clk);
    start  = 1'b0;
    key_in = '1;
    chk("b2b_done_low", 128'(done), 128'(0));
    for (int k = 0; k <= 10; k++) begin
      chk("b2b_valid", 128'(key_valid), 128'(1));
      chk($sformatf("b2b_round%0d", 10 - k), 128'(round_out), 128'(10 - k));
      if (k == 0)  chk("b2b_key10", key_out, zero10);
      if (k == 10) chk("b2b_key0", key_out, 128'(0));
      @(negedge clk);
    end
    chk("b2b_done", 128'(done), 128'(1));
    @(negedge clk);

    // 6: NUM_ROUNDS=1 instance
    start1    = 1'b1;
    key_in    = fips[1];
    key_ready = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    key_in = '0;
    chk("p1_valid", 128'(key_valid1), 128'(1));
    chk("p1_round1", 128'(round_out1), 128'(1));
    chk("p1_key1", key_out1, fips[1]);
    @(negedge clk);
    chk("p1_round0", 128'(round_out1), 128'(0));
    chk("p1_key0", key_out1, fips[0]);
    chk("p1_no_done", 128'(done1), 128'(0));
    @(negedge clk);
    chk("p1_done", 128'(done1), 128'(1));
    chk("p1_valid_end", 128'(key_valid1), 128'(0));
    chk("p1_busy_end", 128'(busy1), 128'(0));
    @(negedge clk);
    chk("p1_done_low", 128'(done1), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
